// File: rtl/fp_conv_arbiter.sv
// Purpose: round-robin share of one fixed-latency conversion unit among NREQ requesters.
// Latency: accept to resp_valid is LAT+1 cycles; req_ready is combinational from req_valid.
// Backpressure: a requester is not granted again until its held result is consumed via resp_ready.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   req_valid/ready/data     per-requester operand handshake (slice i = [i*WIDTH +: WIDTH])
//   unit_valid/operand       issue to the shared unit
//   unit_result              unit output, valid LAT cycles after the matching unit_valid
//   resp_valid/ready/data    per-requester held result (same slicing as req_data)
//   busy                     any requester has an operation in flight or held
module fp_conv_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic                    unit_valid,
  output logic [WIDTH-1:0]        unit_operand,
  input  logic [WIDTH-1:0]        unit_result,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [NREQ*WIDTH-1:0]   resp_data,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW:0]     cand;
  logic [LAT-1:0]  tag_vld;
  logic [IW-1:0]   tag_idx [LAT];

  // Gating with rst keeps req_ready/unit_valid low while reset is held,
  // even if requesters are already presenting operands.
  assign eligible = req_valid & ~pending & {NREQ{~rst}};

  // Search starts at rr_ptr and wraps; the first eligible candidate wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (grant == '0 && eligible[cand[IW-1:0]]) begin
        grant[cand[IW-1:0]] = 1'b1;
        gnt_idx             = cand[IW-1:0];
      end
    end
  end

  assign req_ready  = grant;
  assign unit_valid = |grant;
  assign busy       = |pending;

  always_comb begin
    unit_operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        unit_operand = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      rr_ptr     <= '0;
      tag_vld    <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_idx[k] <= '0;
      end
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      // A granted requester was idle, so it holds no response: set and clear
      // never target the same bit in one cycle.
      pending <= (pending | grant) & ~(resp_valid & resp_ready);

      if (unit_valid) begin
        rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
      end

      // Tag pipeline mirrors the unit's fixed latency and never stalls.
      tag_vld[0] <= unit_valid;
      tag_idx[0] <= gnt_idx;
      for (int k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end

      // A capture can only target a requester with nothing held, so it never
      // collides with that requester's handshake.
      for (int i = 0; i < NREQ; i++) begin
        if (tag_vld[LAT-1] && tag_idx[LAT-1] == IW'(i)) begin
          resp_valid[i]               <= 1'b1;
          resp_data[i*WIDTH +: WIDTH] <= unit_result;
        end else if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_conv_arbiter.sv
// Purpose: scoreboard bench for fp_conv_arbiter with a behavioural arbitration model.
// Latency: the shared unit is modelled as an LAT-stage delay returning operand+1.
// Backpressure: resp_ready is driven both held-high, held-low per requester and randomly.
module tb_fp_conv_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_data;
  logic             unit_valid;
  logic [W-1:0]     unit_operand;
  logic [W-1:0]     unit_result;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready;
  logic [N*W-1:0]   resp_data;
  logic             busy;

  fp_conv_arbiter #(.NREQ(N), .WIDTH(W), .LAT(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .unit_valid   (unit_valid),
    .unit_operand (unit_operand),
    .unit_result  (unit_result),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared unit: not reset, so results of pre-reset issues still appear after
  // release. Idle slots carry random junk that the DUT must ignore.
  logic [W-1:0] upipe [L];
  always @(posedge clk) begin
    upipe[0] <= unit_valid ? unit_operand + W'(1) : W'($urandom);
    for (int k = 1; k < L; k++) upipe[k] <= upipe[k-1];
  end
  assign unit_result = upipe[L-1];

  // Scoreboard and reference model state.
  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         expq [N][$];
  logic [N-1:0] mpend;
  logic [N-1:0] mheld;
  logic [W-1:0] mdata [N];
  int           mptr;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, when inputs and outputs are settled.
  // Model updates made here describe the effect of the next rising edge.
  always @(negedge clk) begin
    int           g;
    int           j;
    logic [N-1:0] erdy;
    logic [W-1:0] eop;
    exp_t         e;
    if (rst) begin
      chk("rst_req_ready", req_ready, '0);
      chk("rst_unit_valid", unit_valid, '0);
      chk("rst_unit_operand", unit_operand, '0);
      chk("rst_busy", busy, '0);
      chk("rst_resp_valid", resp_valid, '0);
      chk("rst_resp_data", resp_data, '0);
      mpend = '0;
      mheld = '0;
      mptr  = 0;
      for (int i = 0; i < N; i++) expq[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (expq[i].size() > 0 && expq[i][0].due == cyc) begin
          mheld[i] = 1'b1;
          mdata[i] = expq[i][0].data;
          void'(expq[i].pop_front());
        end
      end
      chk("resp_valid", resp_valid, mheld);
      for (int i = 0; i < N; i++) begin
        if (mheld[i]) chk("resp_data", resp_data[i*W +: W], mdata[i]);
      end

      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (g < 0 && req_valid[j] && !mpend[j]) g = j;
      end
      erdy = '0;
      eop  = '0;
      if (g >= 0) begin
        erdy[g] = 1'b1;
        eop     = req_data[g*W +: W];
      end
      chk("req_ready", req_ready, erdy);
      chk("unit_valid", unit_valid, (g >= 0));
      chk("unit_operand", unit_operand, eop);
      chk("busy", busy, |mpend);

      if (g >= 0) begin
        mpend[g] = 1'b1;
        e.data   = eop + W'(1);
        e.due    = cyc + L + 1;
        expq[g].push_back(e);
        mptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (mheld[i] && resp_ready[i]) begin
          mheld[i] = 1'b0;
          mpend[i] = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] rr);
    @(posedge clk);
    #1;
    req_valid  = v;
    resp_ready = rr;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_data   = '0;
    mpend      = '0;
    mheld      = '0;
    mptr       = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle
    repeat (3) drive(4'b0000, 4'b1111);

    // Single request from requester 0
    drive(4'b0001, 4'b1111);
    req_data[31:0] = 32'h3FC0_0000;
    repeat (6) drive(4'b0000, 4'b1111);

    // Full contention with immediate consumption
    repeat (14) drive(4'b1111, 4'b1111);

    // Requester 2 backpressured while others keep being served
    repeat (12) drive(4'b1111, 4'b1011);
    repeat (4)  drive(4'b1111, 4'b1111);
    repeat (8)  drive(4'b0000, 4'b1111);

    // Reset one cycle after issuing for requester 3
    drive(4'b1000, 4'b1111);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 4'b1111;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) drive(4'b1111, 4'b1111);
    repeat (8) drive(4'b0000, 4'b1111);

    // Random traffic
    repeat (400) drive(N'($urandom), N'($urandom) | N'($urandom));

    // Drain
    repeat (10) drive(4'b0000, 4'b1111);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
